mutative_data_ctrl: RTL and testbench

MUTATIVE_DATA_CTRL -- requirements
Module: mutative_data_ctrl

---
 rtl/mutative_pkg.sv | 18 +
 rtl/mutative_arb.sv | 50 +++++
 rtl/mutative_data_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mutative_data_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mutative_pkg.sv
// Shared definitions for the mutative data-array controller.
// Holds the default geometry of the data array (line index width,
// line width, byte-enable count), the default starvation limit for
// port A, and the controller state encoding.
package mutative_pkg;

  localparam int ADDR_WIDTH   = 4;
  localparam int DATA_WIDTH   = 256;
  localparam int NUM_WMASKS   = DATA_WIDTH / 8;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_RESP_WAIT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/mutative_arb.sv
// Two-port arbiter with starvation protection.
// Port B (fill/writeback) normally wins. Port A (CPU hit path) wins
// once it has watched STARVE_LIMIT consecutive B grants while waiting.
//
// Ports:
//   clk0, rst0_n      clock, async active-low reset
//   a_valid, b_valid  request present on each port
//   enable            controller can accept a request this cycle
//   grant_a, grant_b  one-hot (or zero) grant for this cycle
module mutative_arb #(
  parameter int STARVE_LIMIT = mutative_pkg::STARVE_LIMIT
) (
  input  logic clk0,
  input  logic rst0_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic enable,
  output logic grant_a,
  output logic grant_b
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    grant_a  = enable && a_valid && (!b_valid || starved);
    grant_b  = enable && b_valid && !(a_valid && starved);
    starve_d = starve_q;
    // The count only means "B grants while A waited", so any cycle
    // without an A request or with an A grant restarts it.
    if (!a_valid || grant_a) begin
      starve_d = '0;
    end else if (grant_b && !starved) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mutative_data_ctrl.sv
// Data-array controller: clears the SRAM after reset, then arbitrates
// two request ports (A: CPU hit path, B: line fill/writeback) onto a
// single-port synchronous SRAM and returns read data with a
// valid/ready response handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_INIT    | writing zeros to lines 0..2**ADDR_WIDTH-1, no requests
// ST_SERVE   | accepting requests; read data of last accept on rdata
// ST_RESP_WAIT | owner has not taken its read data yet; SRAM idle
//
// Ports:
//   clk0, rst0_n                       clock, async active-low reset
//   a_valid/a_ready, a_we, a_addr,
//   a_wmask, a_wdata                   port A request
//   a_rvalid/a_rready, a_rdata         port A read response
//   b_*                                port B, same as port A
//   csb0, web0, addr0, wmask0, din0,
//   dout0                              SRAM port (active-low selects)
//   init_done                          array clear finished
module mutative_data_ctrl #(
  parameter int ADDR_WIDTH   = mutative_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = mutative_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS   = mutative_pkg::NUM_WMASKS,
  parameter int STARVE_LIMIT = mutative_pkg::STARVE_LIMIT
) (
  input  logic                  clk0,
  input  logic                  rst0_n,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  input  logic                  a_rready,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  input  logic                  b_rready,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,

  output logic                  init_done
);

  import mutative_pkg::*;

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic rsp_pend;
  logic owner_rready;
  logic arb_en;
  logic grant_a;
  logic grant_b;
  logic rdata_live;

  assign rsp_pend     = a_rvalid_q | b_rvalid_q;
  assign owner_rready = (a_rvalid_q & a_rready) | (b_rvalid_q & b_rready);
  // A new grant may overlap the first response cycle only if that
  // response is being consumed now, giving one read per cycle.
  assign arb_en       = (state_q == ST_SERVE) && (!rsp_pend || owner_rready);

  mutative_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk0    (clk0),
    .rst0_n  (rst0_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .enable  (arb_en),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    a_rvalid_d  = a_rvalid_q && !a_rready;
    b_rvalid_d  = b_rvalid_q && !b_rready;
    rdata_d     = rdata_q;
    csb0        = 1'b1;
    web0        = 1'b1;
    addr0       = '0;
    wmask0      = '0;
    din0        = '0;

    case (state_q)
      ST_INIT: begin
        csb0       = 1'b0;
        web0       = 1'b0;
        wmask0     = '1;
        addr0      = init_cnt_q;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == '1) begin
          state_d     = ST_SERVE;
          init_done_d = 1'b1;
        end
      end

      ST_SERVE: begin
        if (rsp_pend) begin
          // SRAM output is only guaranteed for the cycle after the read,
          // so keep a copy in case the owner stalls.
          rdata_d = dout0;
          if (!owner_rready) begin
            state_d = ST_RESP_WAIT;
          end
        end
        if (grant_a) begin
          csb0       = 1'b0;
          web0       = !a_we;
          addr0      = a_addr;
          wmask0     = a_wmask;
          din0       = a_wdata;
          a_rvalid_d = a_rvalid_d | !a_we;
        end else if (grant_b) begin
          csb0       = 1'b0;
          web0       = !b_we;
          addr0      = b_addr;
          wmask0     = b_wmask;
          din0       = b_wdata;
          b_rvalid_d = b_rvalid_d | !b_we;
        end
      end

      ST_RESP_WAIT: begin
        if (owner_rready) begin
          state_d = ST_SERVE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // First response cycle passes SRAM data straight through; afterwards
  // the captured copy is presented.
  assign rdata_live = (state_q == ST_SERVE) && rsp_pend;
  assign a_rdata    = rdata_live ? dout0 : rdata_q;
  assign b_rdata    = rdata_live ? dout0 : rdata_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_mutative_data_ctrl.sv
// Bench for mutative_data_ctrl: behavioural SRAM, directed vectors,
// corner-case sequences and a randomized run against a reference model.
module tb_mutative_data_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 256;
  localparam int NW  = 32;
  localparam int LIM = 4;

  typedef logic [DW-1:0] word_t;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          a_valid, a_ready, a_we, a_rvalid, a_rready;
  logic [AW-1:0] a_addr;
  logic [NW-1:0] a_wmask;
  word_t         a_wdata, a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid, b_rready;
  logic [AW-1:0] b_addr;
  logic [NW-1:0] b_wmask;
  word_t         b_wdata, b_rdata;
  logic          csb0, web0, init_done;
  logic [AW-1:0] addr0;
  logic [NW-1:0] wmask0;
  word_t         din0, dout0;

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  mutative_data_ctrl dut (
    .clk0(clk0), .rst0_n(rst0_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wmask(a_wmask), .a_wdata(a_wdata), .a_rvalid(a_rvalid),
    .a_rready(a_rready), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wmask(b_wmask), .b_wdata(b_wdata), .b_rvalid(b_rvalid),
    .b_rready(b_rready), .b_rdata(b_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .wmask0(wmask0),
    .din0(din0), .dout0(dout0), .init_done(init_done)
  );

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Synchronous SRAM; output is garbage after any cycle that did not read.
  word_t sram [16];
  always @(posedge clk0) begin
    if (!csb0 && web0) begin
      dout0 <= sram[addr0];
    end else begin
      dout0 <= rand_word();
      if (!csb0) begin
        for (int i = 0; i < NW; i++)
          if (wmask0[i]) sram[addr0][i*8 +: 8] <= din0[i*8 +: 8];
      end
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_we = 0; a_addr = '0; a_wmask = '0; a_wdata = '0; a_rready = 1;
    b_valid = 0; b_we = 0; b_addr = '0; b_wmask = '0; b_wdata = '0; b_rready = 1;
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, word_t'({init_done, a_ready, b_ready, a_rvalid, b_rvalid}), word_t'(5'b0));
  endtask

  // Entered with reset asserted, at +1 after a clock edge.
  task automatic run_init(input int abort_at);
    a_valid = 1; a_we = 1; b_valid = 1; b_we = 1;
    rst0_n = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("init_pins%0d", i),
          word_t'({csb0, web0, addr0, wmask0, init_done, a_ready, b_ready}),
          word_t'({1'b0, 1'b0, 4'(i), {NW{1'b1}}, 3'b000}));
      chk($sformatf("init_din%0d", i), din0, '0);
      if (i == abort_at) begin
        rst0_n = 0;
        #1;
        chk("abort_reset_state", word_t'({init_done, a_ready, b_ready, a_rvalid, b_rvalid, addr0}),
            word_t'({5'b0, 4'd0}));
        return;
      end
      step();
    end
    a_valid = 0; b_valid = 0;
    #1;
    chk("init_done_after16", word_t'({init_done, csb0, web0}), word_t'(3'b111));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [NW-1:0] mask;
    word_t         wdata;
    word_t         exp;
  } vec_t;

  vec_t  vecs [9];
  word_t shadow [16];
  bit    pend, pend_b, pend_first, a_took, b_took, en, starved, ga, gb, own_rdy;
  word_t pend_data;
  int    streak;

  initial begin
    idle_inputs();
    rst0_n = 0;
    #1;
    chk_reset_state("reset_state");
    step(); step();
    run_init(-1);
    step();

    vecs[0] = '{0, 4'd7, '0, '0, '0};
    vecs[1] = '{1, 4'd3, {NW{1'b1}}, {32{8'hA5}}, '0};
    vecs[2] = '{0, 4'd3, '0, '0, {32{8'hA5}}};
    vecs[3] = '{1, 4'd2, 32'h0000_0001, {32{8'hFF}}, '0};
    vecs[4] = '{0, 4'd2, '0, '0, 256'hFF};
    vecs[5] = '{1, 4'd3, 32'h8000_0000, {32{8'h3C}}, '0};
    vecs[6] = '{0, 4'd3, '0, '0, {8'h3C, {31{8'hA5}}}};
    vecs[7] = '{1, 4'd2, 32'h0000_0006, {32{8'h5A}}, '0};
    vecs[8] = '{0, 4'd2, '0, '0, 256'h5A5AFF};

    for (int k = 0; k < 9; k++) begin
      a_valid = 1; a_we = vecs[k].we; a_addr = vecs[k].addr;
      a_wmask = vecs[k].mask; a_wdata = vecs[k].wdata; a_rready = 1;
      #1;
      chk($sformatf("vec%0d_accept", k), word_t'({a_ready, b_ready, csb0, web0, addr0}),
          word_t'({1'b1, 1'b0, 1'b0, !vecs[k].we, vecs[k].addr}));
      step();
      a_valid = 0;
      if (!vecs[k].we) begin
        #1;
        chk($sformatf("vec%0d_rvalid", k), word_t'({a_rvalid, b_rvalid}), word_t'(2'b10));
        chk($sformatf("vec%0d_rdata", k), a_rdata, vecs[k].exp);
        step();
      end
    end

    // back-to-back reads
    a_valid = 1; a_we = 0; a_addr = 3;
    step();
    a_addr = 2;
    #1;
    chk("b2b_first", word_t'({a_rvalid, a_ready, csb0, addr0}), word_t'({1'b1, 1'b1, 1'b0, 4'd2}));
    chk("b2b_first_data", a_rdata, {8'h3C, {31{8'hA5}}});
    step();
    a_valid = 0;
    #1;
    chk("b2b_second_rvalid", word_t'(a_rvalid), word_t'(1'b1));
    chk("b2b_second_data", a_rdata, 256'h5A5AFF);
    step();
    #1;
    chk("b2b_done", word_t'({a_rvalid, b_rvalid}), word_t'(2'b00));
    step();

    // starvation: both ports held, writes to lines 0 and 1
    a_valid = 1; a_we = 1; a_addr = 0; a_wmask = '1; a_wdata = rand_word();
    b_valid = 1; b_we = 1; b_addr = 1; b_wmask = '1; b_wdata = rand_word();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("starve_grant%0d", c), word_t'({a_ready, b_ready}),
          word_t'((c % 5 == 4) ? 2'b10 : 2'b01));
      step();
    end
    idle_inputs();
    step();

    // B read stalled for three cycles
    b_valid = 1; b_we = 0; b_addr = 3; b_rready = 0;
    step();
    a_valid = 1; a_we = 1; b_we = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) b_rready = 1;
      #1;
      chk($sformatf("stall%0d_flags", c), word_t'({a_rvalid, b_rvalid, a_ready, b_ready, csb0}),
          word_t'(5'b01001));
      chk($sformatf("stall%0d_rdata", c), b_rdata, {8'h3C, {31{8'hA5}}});
      step();
    end
    #1;
    chk("stall_release", word_t'({b_rvalid, b_ready}), word_t'(2'b01));
    idle_inputs();
    step();

    // reset while a response is held
    a_valid = 1; a_we = 0; a_addr = 3; a_rready = 0;
    step();
    a_valid = 0;
    step();
    #1;
    chk("pend_before_reset", word_t'(a_rvalid), word_t'(1'b1));
    rst0_n = 0;
    #1;
    chk_reset_state("reset_discards_resp");
    a_rready = 1;
    step(); step();
    run_init(-1);
    idle_inputs();
    step();

    // randomized run against reference model
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    pend = 0; pend_b = 0; pend_first = 0; pend_data = '0; streak = 0;
    a_took = 1; b_took = 1;
    for (int c = 0; c < 600; c++) begin
      if (!a_valid || a_took) begin
        a_valid = ($urandom % 3) != 0; a_we = $urandom_range(0, 1);
        a_addr = 4'($urandom_range(0, 15)); a_wmask = $urandom; a_wdata = rand_word();
      end
      if (!b_valid || b_took) begin
        b_valid = ($urandom % 3) != 0; b_we = $urandom_range(0, 1);
        b_addr = 4'($urandom_range(0, 15)); b_wmask = $urandom; b_wdata = rand_word();
      end
      a_rready = ($urandom % 4) != 0;
      b_rready = ($urandom % 4) != 0;
      #1;
      own_rdy = pend_b ? b_rready : a_rready;
      en      = !pend || (pend_first && own_rdy);
      starved = (streak == LIM);
      ga      = en && a_valid && (!b_valid || starved);
      gb      = en && b_valid && !(a_valid && starved);
      chk("rnd_ready", word_t'({a_ready, b_ready}), word_t'({ga, gb}));
      chk("rnd_rvalid", word_t'({a_rvalid, b_rvalid}), word_t'({pend && !pend_b, pend && pend_b}));
      if (pend) chk("rnd_rdata", pend_b ? b_rdata : a_rdata, pend_data);
      chk("rnd_csb0", word_t'(csb0), word_t'(!(ga || gb)));
      if (ga) begin
        chk("rnd_a_pins", word_t'({web0, addr0}), word_t'({!a_we, a_addr}));
        if (a_we) chk("rnd_a_wdata", din0, a_wdata);
      end
      if (gb) begin
        chk("rnd_b_pins", word_t'({web0, addr0}), word_t'({!b_we, b_addr}));
        if (b_we) chk("rnd_b_wdata", din0, b_wdata);
      end
      if (pend) begin
        if (own_rdy) pend = 0;
        else pend_first = 0;
      end
      if (ga || gb) begin
        if (ga ? a_we : b_we) begin
          for (int j = 0; j < NW; j++)
            if (ga ? a_wmask[j] : b_wmask[j])
              shadow[ga ? a_addr : b_addr][j*8 +: 8] = ga ? a_wdata[j*8 +: 8] : b_wdata[j*8 +: 8];
        end else begin
          pend = 1; pend_b = gb; pend_first = 1;
          pend_data = shadow[ga ? a_addr : b_addr];
        end
      end
      if (!a_valid || ga) streak = 0;
      else if (gb && streak < LIM) streak++;
      a_took = ga; b_took = gb;
      step();
    end
    idle_inputs();
    step(); step(); step();

    // reset pulse during the clear at line 9
    rst0_n = 0;
    #1;
    chk_reset_state("reset_before_abort");
    step();
    run_init(9);
    step(); step();
    run_init(-1);
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
